// File: rtl/tx_frame_scheduler.sv
// rtl/tx_frame_scheduler.sv - arbitrates two frame requesters onto one transmitter with flag fill framing
// Define TXSCHED_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (req0 wins).
module tx_frame_scheduler #(
  parameter int IDLE_CYCLES     = 15,
  parameter int PREFILL_CYCLES  = 16,
  parameter int POSTFILL_CYCLES = 8,
  parameter int STALL_LIMIT     = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       line_idle,
  input  logic       no_clock,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic       last0,
  input  logic       last1,
  output logic       take0,
  output logic       take1,
  output logic [7:0] tx_data,
  output logic       tx_data_available,
  input  logic       tx_data_consumed,
  output logic       tx_flag_fill,
  output logic       tx_eop,
  output logic [1:0] grant,
  output logic       busy,
  output logic       done,
  output logic       aborted
);
  localparam int CW = 16;
  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] PRE_LAST  = CW'(PREFILL_CYCLES - 1);
  localparam logic [CW-1:0] POST_LAST = CW'(POSTFILL_CYCLES - 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_LINE, S_PREFILL, S_DATA, S_POSTFILL} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [1:0]    grant_q, grant_d;
  logic [1:0]    win;
  logic          g_req, g_last, drop;
  logic [7:0]    g_data;

`ifdef TXSCHED_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;

  // ptr_q names the requester preferred on a tie; it moves only on a completed frame
  always_comb begin
    if (req0 && req1) win = ptr_q ? 2'b10 : 2'b01;
    else              win = req0 ? 2'b01 : 2'b10;
  end
`else
  always_comb begin
    win = req0 ? 2'b01 : 2'b10;
  end
`endif

  assign g_req  = |(grant_q & {req1, req0});
  assign g_data = grant_q[1] ? data1 : data0;
  assign g_last = grant_q[1] ? last1 : last0;
  assign grant  = grant_q;
  assign busy   = (state_q != S_IDLE);

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    stall_d           = stall_q;
    grant_d           = grant_q;
`ifdef TXSCHED_ROUND_ROBIN_EN
    ptr_d             = ptr_q;
`endif
    drop              = 1'b0;
    take0             = 1'b0;
    take1             = 1'b0;
    tx_data           = 8'h00;
    tx_data_available = 1'b0;
    tx_flag_fill      = 1'b0;
    tx_eop            = 1'b0;
    done              = 1'b0;
    aborted           = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        stall_d = '0;
        if (req0 || req1) begin
          grant_d = win;
          state_d = S_WAIT_LINE;
        end
      end
      S_WAIT_LINE: begin
        if (no_clock)                 aborted = 1'b1;
        else if (!g_req)              drop    = 1'b1;
        else if (!line_idle)          cnt_d   = '0;
        else if (cnt_q == IDLE_LAST) begin
          cnt_d   = '0;
          state_d = S_PREFILL;
        end else                      cnt_d   = cnt_q + 1'b1;
      end
      S_PREFILL: begin
        if (no_clock)    aborted = 1'b1;
        else if (!g_req) drop    = 1'b1;
        else begin
          tx_flag_fill = 1'b1;
          if (cnt_q == PRE_LAST) begin
            cnt_d   = '0;
            stall_d = '0;
            state_d = S_DATA;
          end else cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        // abort outranks a take in the same cycle, even one carrying last
        if (no_clock || !g_req || stall_q == STALL_MAX) aborted = 1'b1;
        else begin
          tx_data           = g_data;
          tx_eop            = g_last;
          tx_data_available = 1'b1;
          if (tx_data_consumed) begin
            take0   = grant_q[0];
            take1   = grant_q[1];
            stall_d = '0;
            if (g_last) begin
              cnt_d   = '0;
              state_d = S_POSTFILL;
            end
          end else stall_d = stall_q + 1'b1;
        end
      end
      S_POSTFILL: begin
        if (no_clock) aborted = 1'b1;
        else begin
          tx_flag_fill = 1'b1;
          if (cnt_q == POST_LAST) begin
            done = 1'b1;
            drop = 1'b1;
`ifdef TXSCHED_ROUND_ROBIN_EN
            ptr_d = grant_q[0];
`endif
          end else cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (aborted || drop) begin
      state_d = S_IDLE;
      grant_d = '0;
      cnt_d   = '0;
      stall_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      stall_q <= '0;
      grant_q <= '0;
`ifdef TXSCHED_ROUND_ROBIN_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      grant_q <= grant_d;
`ifdef TXSCHED_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end
endmodule

// File: tb/tb_tx_frame_scheduler.sv
// tb/tb_tx_frame_scheduler.sv - randomized scoreboard bench for tx_frame_scheduler
module tb_tx_frame_scheduler;
  localparam int IDLE  = 15;
  localparam int PRE   = 16;
  localparam int POST  = 8;
  localparam int STALL = 64;
`ifdef TXSCHED_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic       clk = 1'b0, reset_n = 1'b0, line_idle = 1'b1, no_clock = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, last0 = 1'b0, last1 = 1'b0, tx_data_consumed = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       take0, take1, tx_data_available, tx_flag_fill, tx_eop, busy, done, aborted;
  logic [7:0] tx_data;
  logic [1:0] grant;

  tx_frame_scheduler #(.IDLE_CYCLES(IDLE), .PREFILL_CYCLES(PRE), .POSTFILL_CYCLES(POST),
                       .STALL_LIMIT(STALL)) dut (
    .clk(clk), .reset_n(reset_n), .line_idle(line_idle), .no_clock(no_clock),
    .req0(req0), .req1(req1), .data0(data0), .data1(data1), .last0(last0), .last1(last1),
    .take0(take0), .take1(take1), .tx_data(tx_data), .tx_data_available(tx_data_available),
    .tx_data_consumed(tx_data_consumed), .tx_flag_fill(tx_flag_fill), .tx_eop(tx_eop),
    .grant(grant), .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;

  typedef enum int {K_GRANT, K_FLAG, K_TAKE, K_DONE, K_ABORT} kind_e;
  typedef struct { kind_e kind; int cyc; logic [15:0] val; } ev_t;
  ev_t        expq[$];
  int         last_ev;
  int         rr_ptr = 0;
  int         force_dly = -1;
  logic [7:0] byt [8];

  task automatic expect_ev(input kind_e k, input int c, input logic [15:0] v);
    ev_t e;
    e.kind = k; e.cyc = c; e.val = v;
    expq.push_back(e);
    if (c > last_ev) last_ev = c;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic observe(input kind_e k, input logic [15:0] v);
    ev_t e;
    total++;
    if (expq.size() == 0) begin
      bad++;
      $display("FAIL unexpected_%s: got cyc=%0d val=%h, required no event", k.name(), cyc, v);
    end else begin
      e = expq.pop_front();
      if (e.kind != k || e.cyc != cyc || e.val != v) begin
        bad++;
        $display("FAIL event: got %s cyc=%0d val=%h, required %s cyc=%0d val=%h",
                 k.name(), cyc, v, e.kind.name(), e.cyc, e.val);
      end
    end
  endtask

  logic       prev_flag = 1'b0;
  logic [1:0] prev_grant = 2'b00;
  always @(negedge clk) begin
    if (grant != prev_grant) observe(K_GRANT, {14'd0, grant});
    if (tx_flag_fill && !prev_flag) observe(K_FLAG, {6'd0, tx_data_available, tx_eop, tx_data});
    if (take0 || take1) observe(K_TAKE, {4'd0, take1, take0, tx_data_available, tx_eop, tx_data});
    if (done) observe(K_DONE, {13'd0, tx_flag_fill, grant});
    if (aborted) observe(K_ABORT, {3'd0, take1, take0, tx_data_available, tx_flag_fill, tx_eop, tx_data});
    prev_grant = grant;
    prev_flag  = tx_flag_fill;
  end

  // mode: 0 normal, 1 stall on byte jp, 2 underrun before byte jp, 3 no_clock at postfill cycle jp,
  //       4 silent drop at prefill cycle jp, 5 reset while byte jp is presented
  task automatic run_frame(input logic [1:0] mask, input int n, input int gk, input int gg,
                           input int mode, input int jp);
    int w, t0, p, s, t, f, d, a, r, q, reqw_end, req_end, dlo, dhi, idx;
    bit stopped, eop, rw, ro;
    bit cons [int];
    @(posedge clk); #1;
    t0 = cyc; last_ev = t0;
    a = -1; r = -1; q = -1; dhi = -1; reqw_end = 0; req_end = 0; stopped = 1'b0;
    w = (mask == 2'b01) ? 0 : (mask == 2'b10) ? 1 : (RR_EN ? rr_ptr : 0);
    expect_ev(K_GRANT, t0 + 1, (w == 1) ? 16'd2 : 16'd1);
    p = (gk >= 0) ? t0 + 1 + gk + gg + IDLE : t0 + 1 + IDLE;
    dlo = p + PRE;
    if (mode == 4) begin
      q = p + jp;
      expect_ev(K_FLAG, p, 16'd0);
      expect_ev(K_GRANT, q + 1, 16'd0);
      reqw_end = q - 1; req_end = q;
    end else begin
      expect_ev(K_FLAG, p, 16'd0);
      s = dlo;
      for (int i = 0; i < n && !stopped; i++) begin
        if (mode == 1 && i == jp) begin
          expect_ev(K_ABORT, s + STALL, 16'd0);
          expect_ev(K_GRANT, s + STALL + 1, 16'd0);
          reqw_end = s + STALL; req_end = s + STALL; dhi = s + STALL; stopped = 1'b1;
        end else if (mode == 2 && i == jp) begin
          expect_ev(K_ABORT, s, 16'd0);
          expect_ev(K_GRANT, s + 1, 16'd0);
          cons[s] = 1'b1;
          reqw_end = s - 1; req_end = s; dhi = s; stopped = 1'b1;
        end else if (mode == 5 && i == jp) begin
          r = s;
          expect_ev(K_GRANT, s, 16'd0);
          reqw_end = s; req_end = s; dhi = s; stopped = 1'b1; rr_ptr = 0;
        end else begin
          d = (i == 0 && force_dly >= 0) ? force_dly : int'($urandom_range(0, 3));
          t = s + d;
          eop = (i == n - 1);
          expect_ev(K_TAKE, t, {4'd0, w == 1, w == 0, 1'b1, eop, byt[i]});
          cons[t] = 1'b1;
          s = t + 1;
        end
      end
      if (!stopped) begin
        f = s; dhi = f - 1;
        if (mode == 3) begin
          a = f + jp;
          if (jp > 0) expect_ev(K_FLAG, f, 16'd0);
          expect_ev(K_ABORT, a, 16'd0);
          expect_ev(K_GRANT, a + 1, 16'd0);
          reqw_end = a; req_end = a;
        end else begin
          expect_ev(K_FLAG, f, 16'd0);
          expect_ev(K_DONE, f + POST - 1, (w == 1) ? 16'h0006 : 16'h0005);
          expect_ev(K_GRANT, f + POST, 16'd0);
          reqw_end = f + POST - 1; req_end = f + POST - 1;
          rr_ptr = 1 - w;
        end
      end
    end
    idx = 0;
    for (int c = t0; c <= last_ev + 2; c++) begin
      rw = (c <= reqw_end);
      ro = (mask == 2'b11) && (c <= req_end);
      if (w == 0) begin
        req0 = rw; req1 = ro;
        data0 = (idx < n) ? byt[idx] : 8'h00; last0 = (idx == n - 1);
        data1 = 8'($urandom); last1 = 1'($urandom);
      end else begin
        req1 = rw; req0 = ro;
        data1 = (idx < n) ? byt[idx] : 8'h00; last1 = (idx == n - 1);
        data0 = 8'($urandom); last0 = 1'($urandom);
      end
      line_idle = !(gk >= 0 && c >= t0 + 1 + gk && c < t0 + 1 + gk + gg);
      no_clock = (c == a);
      if (cons.exists(c))          tx_data_consumed = 1'b1;
      else if (c >= dlo && c <= dhi) tx_data_consumed = 1'b0;
      else                         tx_data_consumed = 1'($urandom);
      if (r >= 0 && c == r + 2) reset_n = 1'b1;
      if (c == r) begin
        #1 reset_n = 1'b0;
        #1 check("reset_async_outputs",
                 32'({take0, take1, tx_data, tx_data_available, tx_flag_fill, tx_eop,
                      grant, busy, done, aborted}), 32'd0);
      end
      @(negedge clk);
      if ((w == 0 && take0) || (w == 1 && take1)) idx++;
      @(posedge clk); #1;
    end
    req0 = 1'b0; req1 = 1'b0; no_clock = 1'b0; tx_data_consumed = 1'b0; line_idle = 1'b1;
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL missing_events: got %0d outstanding (first %s cyc=%0d), required 0",
               expq.size(), expq[0].kind.name(), expq[0].cyc);
      expq.delete();
    end
    check("idle_after_frame", 32'({busy, grant}), 32'd0);
  endtask

  task automatic rand_bytes();
    for (int i = 0; i < 8; i++) byt[i] = 8'($urandom);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish, required finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int gk;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          32'({take0, take1, tx_data, tx_data_available, tx_flag_fill, tx_eop,
               grant, busy, done, aborted}), 32'd0);
    reset_n = 1'b1;

    byt[0] = 8'h53; byt[1] = 8'h01; byt[2] = 8'h02;
    run_frame(2'b10, 3, -1, 0, 0, 0);
    rand_bytes(); run_frame(2'b11, 2, -1, 0, 0, 0);
    rand_bytes(); run_frame(2'b11, 2, -1, 0, 0, 0);
    rand_bytes(); run_frame(2'b01, 2, 9, 3, 0, 0);
    rand_bytes(); force_dly = STALL - 1; run_frame(2'b10, 1, -1, 0, 0, 0); force_dly = -1;
    rand_bytes(); run_frame(2'b01, 3, -1, 0, 1, 1);
    rand_bytes(); run_frame(2'b10, 3, -1, 0, 2, 1);
    rand_bytes(); run_frame(2'b01, 2, -1, 0, 3, int'($urandom_range(0, POST - 1)));
    rand_bytes(); run_frame(2'b10, 2, -1, 0, 3, 0);
    rand_bytes(); run_frame(2'b11, 2, -1, 0, 3, POST - 1);
    rand_bytes(); run_frame(2'b01, 2, -1, 0, 4, 5);
    rand_bytes(); run_frame(2'b10, 3, -1, 0, 5, 1);
    for (int k = 0; k < 6; k++) begin
      rand_bytes();
      gk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, IDLE - 1)) : -1;
      run_frame(2'($urandom_range(1, 3)), int'($urandom_range(1, 4)), gk,
                int'($urandom_range(1, 4)), 0, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tx_frame_scheduler.md
TX_FRAME_SCHEDULER -- requirements
Module: tx_frame_scheduler

Interface
REQ-001 Parameter IDLE_CYCLES, default 15: consecutive line_idle cycles required before a frame may start.
REQ-002 Parameter PREFILL_CYCLES, default 16: flag-fill cycles (2 flags) driven before the first byte.
REQ-003 Parameter POSTFILL_CYCLES, default 8: flag-fill cycles driven after the eop byte is consumed.
REQ-004 Parameter STALL_LIMIT, default 64: maximum cycles the block waits for tx_data_consumed on one byte.
REQ-005 clk  in  1  transmit bit clock; all state changes occur on its rising edge.
REQ-006 reset_n  in  1  reset, asynchronous, active-low.
REQ-007 line_idle  in  1  receiver reports line idle.
REQ-008 no_clock  in  1  receiver reports loss of line clock.
REQ-009 req0, req1  in  1 each  frame request; req0 is the auto-ACK port, req1 is the host port.
REQ-010 data0, data1  in  8 each  current byte of each requester.
REQ-011 last0, last1  in  1 each  current byte is the final byte of the frame.
REQ-012 take0, take1  out  1 each  one-cycle strobe: current byte accepted; the requester presents the next byte on the following cycle.
REQ-013 tx_data  out  8  byte to the transmitter.
REQ-014 tx_data_available  out  1  tx_data valid.
REQ-015 tx_data_consumed  in  1  transmitter has taken tx_data this cycle.
REQ-016 tx_flag_fill  out  1  transmitter sends flags.
REQ-017 tx_eop  out  1  tx_data is the last byte.
REQ-018 grant  out  2  one-hot owner of the transmitter, 00 when free.
REQ-019 busy  out  1  state is not IDLE.
REQ-020 done, aborted  out  1 each  one-cycle completion and abort strobes.

Function
REQ-021 States are IDLE, WAIT_LINE, PREFILL, DATA, POSTFILL.
REQ-022 IDLE: if any req is high, the block SHALL latch grant per REQ-033 and enter WAIT_LINE on the next cycle.
REQ-023 WAIT_LINE: an idle counter SHALL increment while line_idle is high and clear when it is low; at count IDLE_CYCLES the block enters PREFILL.
REQ-024 PREFILL: tx_flag_fill=1 for exactly PREFILL_CYCLES cycles, then enter DATA.
REQ-025 DATA: tx_data, tx_eop and tx_data_available SHALL combinationally equal the granted requester's data, last and req, with tx_flag_fill=0.
REQ-026 DATA: take<n> = tx_data_consumed AND grant[n]; the stall counter clears on every take.
REQ-027 A take with last high SHALL enter POSTFILL on the next cycle.
REQ-028 POSTFILL: tx_flag_fill=1 for POSTFILL_CYCLES cycles, then pulse done, clear grant and enter IDLE.
REQ-029 Abort: no_clock high in any non-IDLE state, granted req low in DATA (underrun), or stall counter reaching STALL_LIMIT SHALL pulse aborted, force all tx outputs to 0 and return to IDLE next cycle.
REQ-030 Abort takes precedence over a simultaneous take, including a take with last high.
REQ-031 Grant SHALL NOT change between leaving IDLE and returning to IDLE; a non-granted req is ignored.
REQ-032 Granted req dropping in WAIT_LINE or PREFILL SHALL return to IDLE silently, with no aborted pulse.
REQ-033 Arbitration without the REQ-039 macro: fixed priority, req0 wins.

Reset
REQ-034 reset_n low SHALL immediately force state IDLE and clear all counters.
REQ-035 Reset SHALL force all outputs to 0, grant to 00 and the round-robin pointer to requester 0.
REQ-036 Reset asserted mid-frame SHALL produce no done or aborted pulse.
REQ-037 After reset_n rises, the first grant is possible on the first clk edge.

Configuration
REQ-038 Macro TXSCHED_ROUND_ROBIN_EN selects the arbitration scheme.
REQ-039 With TXSCHED_ROUND_ROBIN_EN defined, arbitration is round-robin: on simultaneous requests the requester other than the last granted one wins, and the pointer updates only on done.
REQ-040 Without TXSCHED_ROUND_ROBIN_EN, arbitration is fixed priority per REQ-033 and no pointer register exists.

Verification
REQ-041 req1 with 3-byte frame 0x53,0x01,0x02 (last on 0x02), line_idle=1 -> 15 WAIT_LINE cycles, 16 flag cycles, three take1 strobes, tx_eop with 0x02, 8 flag cycles, done pulse, grant=00.
REQ-042 req0 and req1 raised in the same cycle -> grant=01; with TXSCHED_ROUND_ROBIN_EN and a second simultaneous request after done -> grant=10.
REQ-043 line_idle toggles low at WAIT_LINE cycle 10 -> counter restarts; PREFILL begins 15 cycles after line_idle returns high.
REQ-044 tx_data_consumed held low for 64 cycles in DATA -> aborted pulse, tx_data_available=0, state IDLE.
REQ-045 req1 drops after the first take -> aborted pulse; no_clock rises during POSTFILL -> aborted, no done pulse.
REQ-046 reset_n pulsed low mid-DATA -> all outputs 0 asynchronously; neither done nor aborted pulses.
